// File: rtl/epp_regfile.sv
// Register-bus responder for the EPP front end: scratch registers, ID/status block and the command FIFO.
// Optional macro EPP_REGFILE_TIMEOUT_EN drops a FIFO write that stays stalled for TIMEOUT cycles.
module epp_regfile #(
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ip_addr,
    input  logic [7:0] ip_do,
    input  logic       ip_wr,
    input  logic       ip_rd,
    output logic [7:0] ip_di,
    output logic       ip_do_rdy,
    output logic [7:0] cmd_data,
    output logic       cmd_valid,
    input  logic       cmd_ready
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [7:0] A_STATUS   = 8'h10;
    localparam logic [7:0] A_FIFO     = 8'h11;
    localparam logic [7:0] A_CTRL     = 8'h12;
    localparam logic [7:0] A_ID       = 8'h13;
    localparam logic [7:0] A_COUNT    = 8'h14;
    localparam logic [7:0] ID_VALUE   = 8'hA5;
    localparam logic [3:0] LAT_LOAD   = 4'(RD_LATENCY - 1);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WR, STALL, RD} state_t;

    state_t        state_reg, state_next;
    logic [7:0]    addr_reg, wdata_reg;
    logic [3:0]    lat_reg, lat_next;
    logic [7:0]    scratch_reg [8];
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic [7:0]    head_reg, head_next;
    logic [7:0]    ip_di_reg;
    logic          udf_reg;
    logic          ovf;

    logic          push, latch, flush, clear_flags, scratch_we, drop;
    logic          cons_pop, has_space, host_fifo_rd, host_pop;
    logic [1:0]    pop_cnt;
    logic [7:0]    second_entry, host_data, status, rdata;

`ifdef EPP_REGFILE_TIMEOUT_EN
    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);
    logic       ovf_reg;
    logic [7:0] tcnt_reg;
    assign ovf = ovf_reg;
`else
    logic unused_timeout;
    assign ovf            = 1'b0;
    assign unused_timeout = ^8'(TIMEOUT);
`endif

    assign cmd_valid = (count_reg != '0);
    assign cons_pop  = cmd_valid && cmd_ready;
    // A consumer pop in the same cycle frees the slot the stalled write needs.
    assign has_space = (count_reg != FULL_COUNT) || cons_pop;

    always_comb begin
        state_next  = state_reg;
        lat_next    = lat_reg;
        push        = 1'b0;
        latch       = 1'b0;
        flush       = 1'b0;
        clear_flags = 1'b0;
        scratch_we  = 1'b0;
        drop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ip_wr) begin
                    state_next = WR;
                end else if (ip_rd) begin
                    state_next = RD;
                    lat_next   = LAT_LOAD;
                end
            end
            WR: begin
                state_next = IDLE;
                if (addr_reg == A_FIFO) begin
                    if (has_space) push = 1'b1;
                    else           state_next = STALL;
                end else if (addr_reg == A_CTRL) begin
                    flush       = wdata_reg[0];
                    clear_flags = wdata_reg[1];
                end else begin
                    scratch_we = (addr_reg[7:3] == 5'd0);
                end
            end
            STALL: begin
                if (has_space) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end
`ifdef EPP_REGFILE_TIMEOUT_EN
                else if (tcnt_reg == TCNT_LAST) begin
                    drop       = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            RD: begin
                if (lat_reg == 4'd0) begin
                    latch      = 1'b1;
                    state_next = IDLE;
                end else begin
                    lat_next = lat_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Host pop needs an entry the consumer is not taking this same cycle.
    always_comb begin
        host_fifo_rd = latch && (addr_reg == A_FIFO);
        host_pop     = host_fifo_rd &&
                       (cons_pop ? (count_reg >= (AW+1)'(2)) : (count_reg != '0));
        pop_cnt      = 2'(cons_pop) + 2'(host_pop);
        second_entry = mem[rd_ptr_reg + AW'(1)];
        host_data    = host_pop ? (cons_pop ? second_entry : head_reg) : 8'h00;
        rd_ptr_next  = rd_ptr_reg + AW'(pop_cnt);
        wr_ptr_next  = wr_ptr_reg + AW'(push);
        count_next   = count_reg + (AW+1)'(push) - (AW+1)'(pop_cnt);
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end
        if (count_next == '0)
            head_next = 8'h00;
        else if (push && (wr_ptr_reg == rd_ptr_next))
            head_next = wdata_reg;
        else
            head_next = mem[rd_ptr_next];
    end

    always_comb begin
        status = {count_reg == FULL_COUNT, count_reg == '0, ovf, udf_reg, 4'b0000};
        rdata  = 8'h00;
        if (addr_reg[7:3] == 5'd0) begin
            rdata = scratch_reg[addr_reg[2:0]];
        end else begin
            case (addr_reg)
                A_STATUS: rdata = status;
                A_FIFO:   rdata = host_data;
                A_ID:     rdata = ID_VALUE;
                A_COUNT:  rdata = 8'(count_reg);
                default:  rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            addr_reg   <= 8'h00;
            wdata_reg  <= 8'h00;
            lat_reg    <= 4'd0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= 8'h00;
            ip_di_reg  <= 8'h00;
            udf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            lat_reg    <= lat_next;
            if (state_reg == IDLE && (ip_wr || ip_rd)) begin
                addr_reg  <= ip_addr;
                wdata_reg <= ip_do;
            end
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
            if (latch) ip_di_reg <= rdata;
            if (clear_flags)                    udf_reg <= 1'b0;
            else if (host_fifo_rd && !host_pop) udf_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= wdata_reg;
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_scratch
        always_ff @(posedge clk) begin
            if (!rst_n)
                scratch_reg[gi] <= 8'h00;
            else if (scratch_we && addr_reg[2:0] == 3'(gi))
                scratch_reg[gi] <= wdata_reg;
        end
    end

`ifdef EPP_REGFILE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_reg  <= 1'b0;
            tcnt_reg <= 8'd0;
        end else begin
            tcnt_reg <= (state_reg == STALL) ? tcnt_reg + 8'd1 : 8'd0;
            if (clear_flags) ovf_reg <= 1'b0;
            else if (drop)   ovf_reg <= 1'b1;
        end
    end
`endif

    assign ip_do_rdy = (state_reg == IDLE);
    assign ip_di     = ip_di_reg;
    assign cmd_data  = head_reg;

endmodule

// File: tb/tb_epp_regfile.sv
// Randomized and directed bench for epp_regfile against a queue/array model of the register map.
module tb_epp_regfile;

    localparam int DEPTH      = 16;
    localparam int RD_LATENCY = 2;
`ifdef EPP_REGFILE_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`else
    localparam int TIMEOUT = 255;
`endif
    localparam int BOUND = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ip_addr = 8'h00;
    logic [7:0] ip_do = 8'h00;
    logic       ip_wr = 1'b0;
    logic       ip_rd = 1'b0;
    logic [7:0] ip_di;
    logic       ip_do_rdy;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the register map
    logic [7:0] m_scratch [8];
    logic [7:0] q [$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    epp_regfile #(.DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ip_addr(ip_addr), .ip_do(ip_do), .ip_wr(ip_wr),
        .ip_rd(ip_rd), .ip_di(ip_di), .ip_do_rdy(ip_do_rdy), .cmd_data(cmd_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_status();
        return {q.size() == DEPTH, q.size() == 0, m_ovf, m_udf, 4'b0000};
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (a < 8'h08) return m_scratch[a[2:0]];
        case (a)
            8'h10: return model_status();
            8'h11: begin
                if (q.size() == 0) begin
                    m_udf = 1'b1;
                    return 8'h00;
                end
                return q.pop_front();
            end
            8'h13: return 8'hA5;
            8'h14: return 8'(q.size());
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
        if (a < 8'h08) m_scratch[a[2:0]] = d;
        else if (a == 8'h11) q.push_back(d);
        else if (a == 8'h12) begin
            if (d[0]) q.delete();
            if (d[1]) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_scratch[i] = 8'h00;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endfunction

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d, output int low);
        @(negedge clk);
        ip_addr = a; ip_do = d; ip_wr = 1'b1;
        @(posedge clk); #1;
        ip_wr = 1'b0;
        low = 0;
        while (ip_do_rdy !== 1'b1 && low < BOUND) begin
            low++;
            @(posedge clk); #1;
        end
        $display("wr addr=%02h data=%02h low=%0d", a, d, low);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output int low);
        @(negedge clk);
        ip_addr = a; ip_rd = 1'b1;
        @(posedge clk); #1;
        ip_rd = 1'b0;
        low = 0;
        while (ip_do_rdy !== 1'b1 && low < BOUND) begin
            low++;
            @(posedge clk); #1;
        end
        d = ip_di;
        $display("rd addr=%02h data=%02h low=%0d", a, d, low);
    endtask

    // Consumer handshake cycles; the head must match the model's oldest byte.
    task automatic consume(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmd_ready = 1'b1;
            checks++;
            if (cmd_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL cmd_valid got=%b exp=%b", cmd_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if (cmd_data !== q[0]) begin
                    errors++;
                    $display("FAIL cmd_data got=%02h exp=%02h", cmd_data, q[0]);
                end
            end
            @(posedge clk); #1;
            cmd_ready = 1'b0;
            $display("pop data=%02h valid=%b", cmd_data, cmd_valid);
            if (q.size() != 0) void'(q.pop_front());
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        int low;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (ip_do_rdy !== 1'b1 || ip_di !== 8'h00 || cmd_valid !== 1'b0 || cmd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b di=%02h valid=%b data=%02h exp 1/00/0/00",
                     ip_do_rdy, ip_di, cmd_valid, cmd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(8'h13, d, low);
        checks += 2;
        if (d !== 8'hA5) begin errors++; $display("FAIL id got=%02h exp=a5", d); end
        if (low != RD_LATENCY) begin errors++; $display("FAIL id_latency got=%0d exp=%0d", low, RD_LATENCY); end
        bus_read(8'h10, d, low);
        checks += 2;
        if (d !== 8'h40) begin errors++; $display("FAIL status_reset got=%02h exp=40", d); end
        if (low != RD_LATENCY) begin errors++; $display("FAIL status_latency got=%0d exp=%0d", low, RD_LATENCY); end
    endtask

    task automatic test_scratch();
        logic [7:0] d;
        int low;
        bus_write(8'h03, 8'h5C, low);
        model_write(8'h03, 8'h5C);
        checks++;
        if (low != 1) begin errors++; $display("FAIL scratch_wr_low got=%0d exp=1", low); end
        bus_read(8'h03, d, low);
        checks++;
        if (d !== 8'h5C) begin errors++; $display("FAIL scratch_rd got=%02h exp=5c", d); end
    endtask

    task automatic test_full_stall();
        logic [7:0] d;
        int low;
        bus_write(8'h12, 8'h03, low);
        model_write(8'h12, 8'h03);
        for (int i = 0; i < DEPTH; i++) begin
            bus_write(8'h11, 8'(i), low);
            model_write(8'h11, 8'(i));
            checks++;
            if (low != 1) begin errors++; $display("FAIL push_low i=%0d got=%0d exp=1", i, low); end
        end
        @(negedge clk);
        ip_addr = 8'h11; ip_do = 8'hFF; ip_wr = 1'b1;
        @(posedge clk); #1;
        ip_wr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ip_do_rdy !== 1'b0) begin errors++; $display("FAIL stall_held got=%b exp=0", ip_do_rdy); end
        @(negedge clk);
        checks++;
        if (cmd_data !== 8'h00 || cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_head got=%02h/%b exp=00/1", cmd_data, cmd_valid);
        end
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        void'(q.pop_front());
        q.push_back(8'hFF);
        $display("wr addr=11 data=ff released by pop");
        checks++;
        if (ip_do_rdy !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", ip_do_rdy); end
        bus_read(8'h14, d, low);
        checks++;
        if (d !== 8'h10) begin errors++; $display("FAIL count_full got=%02h exp=10", d); end
        consume(DEPTH + 1);
    endtask

    task automatic host_consumer_collision(output logic [7:0] d);
        @(negedge clk);
        ip_addr = 8'h11; ip_rd = 1'b1;
        @(posedge clk); #1;
        ip_rd = 1'b0;
        repeat (RD_LATENCY - 1) @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        d = ip_di;
        $display("rd addr=11 data=%02h with consumer pop", d);
    endtask

    task automatic test_underflow();
        logic [7:0] d;
        int low;
        bus_write(8'h12, 8'h03, low);
        model_write(8'h12, 8'h03);
        bus_read(8'h11, d, low);
        checks += 2;
        if (d !== 8'h00) begin errors++; $display("FAIL empty_pop got=%02h exp=00", d); end
        if (low != RD_LATENCY) begin errors++; $display("FAIL empty_pop_low got=%0d exp=%0d", low, RD_LATENCY); end
        bus_read(8'h10, d, low);
        checks++;
        if (d !== 8'h50) begin errors++; $display("FAIL status_udf got=%02h exp=50", d); end
        bus_write(8'h12, 8'h02, low);
        bus_read(8'h10, d, low);
        checks++;
        if (d !== 8'h40) begin errors++; $display("FAIL status_clear got=%02h exp=40", d); end
        // one entry: consumer takes it, host gets zero and underflow
        bus_write(8'h11, 8'h3A, low);
        host_consumer_collision(d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL collide1 got=%02h exp=00", d); end
        bus_read(8'h10, d, low);
        checks++;
        if (d !== 8'h50) begin errors++; $display("FAIL collide1_status got=%02h exp=50", d); end
        // two entries: consumer takes the head, host gets the next one
        bus_write(8'h12, 8'h02, low);
        bus_write(8'h11, 8'hB1, low);
        bus_write(8'h11, 8'hC2, low);
        host_consumer_collision(d);
        checks += 2;
        if (d !== 8'hC2) begin errors++; $display("FAIL collide2 got=%02h exp=c2", d); end
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL collide2_valid got=%b exp=0", cmd_valid); end
        bus_read(8'h10, d, low);
        checks++;
        if (d !== 8'h40) begin errors++; $display("FAIL collide2_status got=%02h exp=40", d); end
        model_reset_flags_and_fifo();
    endtask

    function automatic void model_reset_flags_and_fifo();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endfunction

    task automatic test_flush();
        logic [7:0] d;
        int low;
        for (int i = 0; i < 3; i++) begin
            bus_write(8'h11, 8'(8'h60 + i), low);
            model_write(8'h11, 8'(8'h60 + i));
        end
        @(negedge clk);
        ip_addr = 8'h12; ip_do = 8'h01; ip_wr = 1'b1;
        @(posedge clk); #1;
        ip_wr = 1'b0;
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        model_write(8'h12, 8'h01);
        $display("wr addr=12 data=01 with consumer pop");
        checks += 2;
        if (ip_do_rdy !== 1'b1) begin errors++; $display("FAIL flush_rdy got=%b exp=1", ip_do_rdy); end
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", cmd_valid); end
        bus_read(8'h14, d, low);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL flush_count got=%02h exp=00", d); end
    endtask

    task automatic test_random();
        logic [7:0] a, d, dv, exp;
        int low, op;
        for (int n = 0; n < 160; n++) begin
            op = $urandom_range(0, 8);
            case (op)
                0, 2, 6, 8: begin
                    if (op == 0) begin a = 8'($urandom_range(0, 7)); d = 8'($urandom); end
                    else if (op == 2) begin a = 8'h11; d = 8'($urandom); end
                    else if (op == 6) begin
                        a = 8'($urandom_range(8, 255));
                        if (a == 8'h11 || a == 8'h12) a = 8'h20;
                        d = 8'($urandom);
                    end else begin a = 8'h12; d = 8'($urandom_range(0, 3)); end
                    if (a == 8'h11 && q.size() == DEPTH) begin
                        consume(1);
                    end else begin
                        bus_write(a, d, low);
                        model_write(a, d);
                        checks++;
                        if (low != 1) begin errors++; $display("FAIL rnd_wr_low addr=%02h got=%0d exp=1", a, low); end
                    end
                end
                7: consume($urandom_range(0, 3));
                default: begin
                    if (op == 1)      a = 8'($urandom_range(0, 7));
                    else if (op == 3) a = 8'h11;
                    else if (op == 4) a = 8'h10;
                    else if (op == 5) a = ($urandom_range(0, 1) == 0) ? 8'h14 : 8'($urandom_range(8, 255));
                    else              a = 8'h13;
                    bus_read(a, dv, low);
                    exp = model_read(a);
                    checks += 2;
                    if (dv !== exp) begin errors++; $display("FAIL rnd_rd addr=%02h got=%02h exp=%02h", a, dv, exp); end
                    if (low != RD_LATENCY) begin errors++; $display("FAIL rnd_rd_low addr=%02h got=%0d exp=%0d", a, low, RD_LATENCY); end
                end
            endcase
        end
        consume(DEPTH + 1);
    endtask

`ifdef EPP_REGFILE_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] d;
        int low;
        bus_write(8'h12, 8'h03, low);
        model_write(8'h12, 8'h03);
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'($urandom_range(0, 8'h76));
            bus_write(8'h11, d, low);
            model_write(8'h11, d);
        end
        bus_write(8'h11, 8'h77, low);
        m_ovf = 1'b1;
        checks++;
        if (low != 1 + TIMEOUT) begin errors++; $display("FAIL timeout_low got=%0d exp=%0d", low, 1 + TIMEOUT); end
        bus_read(8'h10, d, low);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL timeout_status got=%02h exp=%02h", d, model_status()); end
        bus_read(8'h14, d, low);
        checks++;
        if (d !== 8'h10) begin errors++; $display("FAIL timeout_count got=%02h exp=10", d); end
        consume(DEPTH + 1);
    endtask
`endif

    task automatic test_reset_midflight();
        logic [7:0] d;
        int low;
        bus_write(8'h05, 8'h99, low);
        bus_write(8'h11, 8'h12, low);
        bus_write(8'h11, 8'h34, low);
        @(negedge clk);
        ip_addr = 8'h13; ip_rd = 1'b1;
        @(posedge clk); #1;
        ip_rd = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (ip_do_rdy !== 1'b1 || cmd_valid !== 1'b0 || ip_di !== 8'h00) begin
            errors++;
            $display("FAIL midreset got rdy=%b valid=%b di=%02h exp 1/0/00", ip_do_rdy, cmd_valid, ip_di);
        end
        bus_read(8'h05, d, low);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL midreset_scratch got=%02h exp=00", d); end
        bus_read(8'h14, d, low);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL midreset_count got=%02h exp=00", d); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scratch();
        test_full_stall();
        test_underflow();
        test_flush();
        test_random();
`ifdef EPP_REGFILE_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
